// File: rtl/mux2_stream_arbiter_pkg.sv
// Shared types for the two-producer stream arbiter: FSM state encoding and a
// small helper that maps a granted input index to its GRANT state.
package mux2_stream_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  function automatic arb_state_t grant_state(input logic who);
    return who ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/mux2_stream_arbiter_mux2_bus.sv
// WIDTH-wide combinational 2:1 mux; s = 0 selects a, s = 1 selects b.
module mux2_bus #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux2_stream_arbiter.sv
// Round-robin arbiter for two valid/ready producers sharing one registered
// output stream; grants bursts of up to MAX_BURST beats and drives the mux select.
module mux2_stream_arbiter
  import mux2_stream_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
);

  localparam int                CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_BURST);

  arb_state_t       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] mux_y;
  logic             winner;

  logic space, granted, cur_valid, accept;

  // last_grant always names the granted input while in GRANTx, so it doubles
  // as both the mux select and the selector of the active producer's valid.
  assign space     = !out_valid_q || out_ready;
  assign granted   = (state_q != IDLE);
  assign cur_valid = last_grant_q ? in1_valid : in0_valid;
  assign accept    = granted && cur_valid && space;

  assign in0_ready = (state_q == GRANT0) && space;
  assign in1_ready = (state_q == GRANT1) && space;
  assign sel       = last_grant_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = granted || out_valid_q;

  mux2_bus #(.WIDTH(WIDTH)) u_mux (
    .a (in0_data),
    .b (in1_data),
    .s (last_grant_q),
    .y (mux_y)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    winner       = last_grant_q;

    unique case (state_q)
      IDLE: begin
        if (in0_valid || in1_valid) begin
          winner       = (in0_valid && in1_valid) ? !last_grant_q : in1_valid;
          state_d      = grant_state(winner);
          last_grant_d = winner;
          cnt_d        = '0;
        end
      end
      GRANT0, GRANT1: begin
        if (!cur_valid) begin
          state_d = IDLE;
        end else if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_LAST) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A same-cycle drain and accept simply reloads the register.
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_y;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      // NOTE: the payload register is reset too, so out_data reads a defined
      // zero after reset rather than leftover data.
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Self-checking bench for mux2_stream_arbiter: directed contention sequence,
// randomized traffic against a transaction-level model, and async resets.
module tb_mux2_stream_arbiter;

  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid [2];
  logic [WIDTH-1:0] in_data  [2];
  logic             in0_ready, in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             sel;
  logic             busy;

  mux2_stream_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in_valid[0]),
    .in0_data  (in_data[0]),
    .in0_ready (in0_ready),
    .in1_valid (in_valid[1]),
    .in1_data  (in_data[1]),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner = -1 when nobody holds the grant, else the producer
  // index; beats counts accepted beats of the current burst.
  int               owner;
  int               last;
  int               beats;
  logic             m_ov;
  logic [WIDTH-1:0] m_od;
  logic             acc [2];

  bit               recording = 0;
  logic [WIDTH-1:0] seen [$];

  function automatic logic m_ready(input int p);
    return (owner == p) && (!m_ov || out_ready);
  endfunction

  task automatic model_reset();
    owner  = -1;
    last   = 1;
    beats  = 0;
    m_ov   = 1'b0;
    m_od   = '0;
    acc[0] = 1'b0;
    acc[1] = 1'b0;
  endtask

  task automatic compare();
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data",  32'(out_data),  32'(m_od));
    check("sel",       32'(sel),       32'(last));
    check("busy",      32'(busy),      32'((owner >= 0) || m_ov));
    check("in0_ready", 32'(in0_ready), 32'(m_ready(0)));
    check("in1_ready", 32'(in1_ready), 32'(m_ready(1)));
  endtask

  task automatic model_step();
    int w;
    for (int p = 0; p < 2; p++) acc[p] = in_valid[p] && m_ready(p);
    if (m_ov && out_ready) m_ov = 1'b0;
    if (owner < 0) begin
      w = -1;
      if (in_valid[0] && in_valid[1]) w = 1 - last;
      else if (in_valid[0])           w = 0;
      else if (in_valid[1])           w = 1;
      if (w >= 0) begin
        owner = w;
        last  = w;
        beats = 0;
      end
    end else if (acc[owner]) begin
      m_od  = in_data[owner];
      m_ov  = 1'b1;
      beats = beats + 1;
      if (beats == MAX_BURST) owner = -1;
    end else if (!in_valid[owner]) begin
      owner = -1;
    end
  endtask

  // One clock cycle: inputs were set at posedge+1, outputs checked at negedge.
  task automatic tick();
    @(negedge clk);
    compare();
    if (recording && out_valid) seen.push_back(out_data);
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Async reset asserted off-edge; outputs must clear immediately. Inputs for
  // the first post-reset cycle are applied while reset is held.
  task automatic do_reset(input logic v0, input logic v1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_sel",       32'(sel),       32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_in0_ready", 32'(in0_ready), 32'd0);
    check("rst_in1_ready", 32'(in1_ready), 32'd0);
    in_valid[0] = v0;
    in_valid[1] = v1;
    in_data[0]  = WIDTH'($urandom);
    in_data[1]  = WIDTH'($urandom);
    out_ready   = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    for (int p = 0; p < 2; p++) begin
      if (!in_valid[p] || acc[p]) begin
        in_valid[p] = ($urandom_range(0, 3) != 0);
        in_data[p]  = WIDTH'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        in_valid[p] = 1'b0;
      end
    end
    out_ready = ($urandom_range(0, 3) != 0);
  endtask

  logic [WIDTH-1:0] exp_seq [16];
  bit found;

  initial begin
    exp_seq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23,
                8'h14, 8'h15, 8'h16, 8'h17, 8'h24, 8'h25, 8'h26, 8'h27};
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    in_data[0]  = '0;
    in_data[1]  = '0;
    out_ready   = 1'b1;
    model_reset();

    // Contention from reset release: input 0 wins the first tie, then alternate.
    do_reset(1'b1, 1'b1);
    in_data[0] = 8'h10;
    in_data[1] = 8'h20;
    recording  = 1;
    for (int c = 0; c < 21; c++) begin
      if (acc[0]) in_data[0] = in_data[0] + 8'h01;
      if (acc[1]) in_data[1] = in_data[1] + 8'h01;
      tick();
    end
    recording = 0;
    check("contention_count", 32'(seen.size()), 32'd16);
    for (int i = 0; i < 16 && i < seen.size(); i++)
      check($sformatf("contention_beat%0d", i), 32'(seen[i]), 32'(exp_seq[i]));

    // Randomized traffic with backpressure and valid drops.
    for (int c = 0; c < 1500; c++) begin
      rand_inputs();
      tick();
    end

    // Reset in the middle of a GRANT1 burst, after two beats were accepted.
    found = 0;
    for (int c = 0; c < 400 && !found; c++) begin
      if (owner == 1 && beats == 2) found = 1;
      else begin
        rand_inputs();
        tick();
      end
    end
    check("mid_burst_reached", 32'(found), 32'd1);
    do_reset(1'b1, 1'b1);
    tick();
    check("post_reset_tie_sel", 32'(sel), 32'd0);

    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 300; c++) begin
        rand_inputs();
        tick();
      end
      do_reset($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
    end
    for (int c = 0; c < 200; c++) begin
      rand_inputs();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
